cart_rom_reader: RTL and testbench
==================================

Name: cart_rom_reader

Overview:
Read-side counterpart of the cartridge loader. The loader writes CPR/BIN images into SDRAM; this block serves Z80 reads of the Plus lower and upper ROM windows from that image. It maps CPU address plus ASIC paging state to an SDRAM cartridge address, runs a req/ack handshake to memory, and stalls the CPU with a wait signal. A one-entry read latch avoids re-fetching repeated bytes.

Parameters:
CART_BASE, 23'h400000, SDRAM byte address of cartridge bank 0
TIMEOUT, 255, memory-ack timeout in clk_sys cycles (8-bit counter)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
plus_mode  in  1  block active only when 1 (GX4000 or Plus)
cart_loading  in  1  image download in progress; invalidates latch, forces idle
cart_banks  in  6  number of loaded 16 KB banks (0..32)
cpu_addr  in  16  Z80 address
cpu_rd  in  1  Z80 memory read strobe (level)
lower_en  in  1  lower ROM enabled
lower_page  in  2  lower ROM window: 0=0000h, 1=4000h, 2=8000h, 3=0000h
lower_bank  in  3  cartridge bank for lower ROM (0..7)
upper_en  in  1  upper ROM enabled (C000h-FFFFh)
upper_sel  in  8  upper ROM select register value
cart_sel  out  1  cpu_addr is in an enabled cartridge window (combinational)
cpu_dout  out  8  read data
cpu_wait  out  1  stall Z80
mem_addr  out  23  SDRAM byte address
mem_req  out  1  memory request (level, held until ack)
mem_ack  in  1  one-cycle acknowledge, mem_q valid same cycle
mem_q  in  8  memory data
timeout_err  out  1  sticky: a request timed out

Behaviour:
- Reset values: cpu_dout=FFh, cpu_wait=0, mem_req=0, mem_addr=0, timeout_err=0, latch invalid, state IDLE, rd_prev=0.
- Window decode, upper takes priority: upper if upper_en and cpu_addr[15:14]=3. Lower if lower_en and cpu_addr[15:14]=window of lower_page. cart_sel=plus_mode and either window hit.
- Bank mapping:
  - lower uses bank=lower_bank.
  - upper: if upper_sel[7], bank=upper_sel[4:0]; else if upper_sel=07h, bank=3; else bank=1.
- Cart offset: {bank[4:0], cpu_addr[13:0]} (19 bits). mem_addr = CART_BASE + offset, truncated to 23 bits.
- Unmapped: if bank >= cart_banks, the read returns FFh with no memory access and no wait. cart_banks=0 means everything is unmapped.
- Read start: cycle N with cpu_rd=1, rd_prev=0, cart_sel=1, state IDLE, cart_loading=0.
  - Latch hit (valid and tag==offset) or unmapped: cpu_dout updated at N+1, cpu_wait never asserted.
  - Miss: cpu_wait=1 combinationally from cycle N. State goes to REQ at N+1 with mem_req=1 and mem_addr registered.
- FSM states IDLE, REQ, DONE.
  - REQ: counter increments each cycle.
  - REQ, mem_ack=1: cpu_dout<=mem_q, latch<={offset,mem_q,valid}, mem_req<=0, go to DONE. cpu_wait is still 1 in the ack cycle and 0 from DONE onward.
  - REQ, counter==TIMEOUT with no ack: cpu_dout<=FFh, timeout_err<=1, mem_req<=0, latch unchanged, go to DONE.
  - DONE: return to IDLE next cycle.
  - Minimum miss latency is 2 wait cycles (ack in the first REQ cycle).
- cpu_rd dropping during REQ: the request still completes, data is latched, and wait is released normally.
- New read edges while not IDLE are ignored. Reads with plus_mode=0 or cart_sel=0 are ignored, and cpu_dout holds its value.
- cart_loading=1: latch invalidated immediately. In REQ, the block waits for the pending ack or timeout, then returns to IDLE with no latch update. While cart_loading=1 no new reads start and cpu_wait=0 in IDLE.
- timeout_err clears only on reset.
- Asynchronous reset mid-REQ: mem_req drops immediately and any late ack is ignored.

Test Plan:
- cart_banks=4, lower_en=1, lower_page=0, lower_bank=2, read 0123h; mem_ack with mem_q=5Ah after 3 cycles -> mem_addr=408123h, cpu_wait high 4 cycles, cpu_dout=5Ah.
- Repeat the same read -> no mem_req, cpu_wait stays 0, cpu_dout=5Ah at N+1. Change lower_bank to 3 -> miss, mem_addr=40C123h.
- upper_en=1: upper_sel=85h, read C010h -> mem_addr=414010h. upper_sel=07h -> 40C010h. upper_sel=00h -> 404010h. cart_banks=4 with upper_sel=85h -> FFh, no req.
- Miss with mem_ack held low -> mem_req high exactly 255 cycles, cpu_dout=FFh, timeout_err=1 and stays set. Next read completes normally.
- Assert cart_loading during REQ, then ack -> cpu_dout updated, latch invalid, next read of the same address issues mem_req.
- Drive reset_n low mid-REQ -> mem_req=0 and cpu_wait=0 immediately, cpu_dout=FFh. A subsequent ack pulse causes no change.

Source files
------------

// File: rtl/cart_rom_reader.sv
// Serves Z80 reads of the Plus lower/upper cartridge ROM windows from SDRAM.
// Maps CPU address and paging state to SDRAM, stalls the CPU, caches one byte.
module cart_rom_reader #(
    parameter logic [22:0] CART_BASE = 23'h400000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        plus_mode,
    input  logic        cart_loading,
    input  logic [5:0]  cart_banks,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        lower_en,
    input  logic [1:0]  lower_page,
    input  logic [2:0]  lower_bank,
    input  logic        upper_en,
    input  logic [7:0]  upper_sel,
    output logic        cart_sel,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    output logic [22:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_q,
    output logic        timeout_err
);

    localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_dout;
    logic        r_req;
    logic [22:0] r_addr;
    logic        r_tmo_err;
    logic        r_lat_vld;
    logic [18:0] r_lat_tag;
    logic [7:0]  r_lat_data;
    logic [18:0] r_req_off;
    logic [7:0]  r_cnt;
    logic        r_rd_prev;
    logic        r_abort;

    logic [1:0]  w_lwin;
    logic        w_upper_hit;
    logic        w_lower_hit;
    logic        w_sel;
    logic [4:0]  w_bank;
    logic [18:0] w_off;
    logic [22:0] w_addr;
    logic        w_unmapped;
    logic        w_hit;
    logic        w_start;
    logic        w_miss;
    logic        w_wait;

    // Page 3 aliases page 0 for the lower window.
    assign w_lwin      = (lower_page == 2'd3) ? 2'd0 : lower_page;
    assign w_upper_hit = upper_en && (cpu_addr[15:14] == 2'd3);
    assign w_lower_hit = lower_en && (cpu_addr[15:14] == w_lwin);
    assign w_sel       = plus_mode && (w_upper_hit || w_lower_hit);

    always_comb begin
        w_bank = {2'b00, lower_bank};
        if (w_upper_hit) begin
            if (upper_sel[7]) begin
                w_bank = upper_sel[4:0];
            end else if (upper_sel == 8'h07) begin
                w_bank = 5'd3;
            end else begin
                w_bank = 5'd1;
            end
        end
    end

    assign w_off      = {w_bank, cpu_addr[13:0]};
    assign w_addr     = CART_BASE + {4'b0000, w_off};
    assign w_unmapped = ({1'b0, w_bank} >= cart_banks);
    assign w_hit      = r_lat_vld && (r_lat_tag == w_off);
    assign w_start    = cpu_rd && !r_rd_prev && w_sel
                        && (r_state == S_IDLE) && !cart_loading;
    assign w_miss     = w_start && !w_unmapped && !w_hit;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = S_REQ;
                    w_wait      = 1'b1;
                end
            end
            S_REQ: begin
                w_wait = 1'b1;
                if (mem_ack || (r_cnt == LP_TMO)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dout     <= 8'hFF;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_tmo_err  <= 1'b0;
            r_lat_vld  <= 1'b0;
            r_lat_tag  <= '0;
            r_lat_data <= '0;
            r_req_off  <= '0;
            r_cnt      <= '0;
            r_rd_prev  <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_rd_prev <= cpu_rd;
            if (cart_loading) begin
                r_lat_vld <= 1'b0;
            end
            if (w_start && w_unmapped) begin
                r_dout <= 8'hFF;
            end else if (w_start && w_hit) begin
                r_dout <= r_lat_data;
            end
            if (w_miss) begin
                r_req     <= 1'b1;
                r_addr    <= w_addr;
                r_req_off <= w_off;
                r_cnt     <= 8'd1;
                r_abort   <= 1'b0;
            end
            if (r_state == S_REQ) begin
                if (cart_loading) begin
                    r_abort <= 1'b1;
                end
                if (mem_ack) begin
                    r_dout <= mem_q;
                    r_req  <= 1'b0;
                    // A download started mid-fetch makes this byte stale.
                    if (!cart_loading && !r_abort) begin
                        r_lat_tag  <= r_req_off;
                        r_lat_data <= mem_q;
                        r_lat_vld  <= 1'b1;
                    end
                end else if (r_cnt == LP_TMO) begin
                    r_dout    <= 8'hFF;
                    r_tmo_err <= 1'b1;
                    r_req     <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign cart_sel    = w_sel;
    assign cpu_dout    = r_dout;
    assign cpu_wait    = reset_n && w_wait;
    assign mem_addr    = r_addr;
    assign mem_req     = r_req;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_cart_rom_reader.sv
// Directed bench for cart_rom_reader: vector table plus timeout,
// cart_loading and mid-request reset sequences.
module tb_cart_rom_reader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        plus_mode = 1'b1;
    logic        cart_loading = 1'b0;
    logic [5:0]  cart_banks = 6'd4;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0;
    logic        lower_en = 1'b0;
    logic [1:0]  lower_page = '0;
    logic [2:0]  lower_bank = '0;
    logic        upper_en = 1'b0;
    logic [7:0]  upper_sel = '0;
    logic        cart_sel;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [22:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_q = '0;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    cart_rom_reader dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .plus_mode   (plus_mode),
        .cart_loading(cart_loading),
        .cart_banks  (cart_banks),
        .cpu_addr    (cpu_addr),
        .cpu_rd      (cpu_rd),
        .lower_en    (lower_en),
        .lower_page  (lower_page),
        .lower_bank  (lower_bank),
        .upper_en    (upper_en),
        .upper_sel   (upper_sel),
        .cart_sel    (cart_sel),
        .cpu_dout    (cpu_dout),
        .cpu_wait    (cpu_wait),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_q       (mem_q),
        .timeout_err (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        l_en;
        logic [1:0]  l_page;
        logic [2:0]  l_bank;
        logic        u_en;
        logic [7:0]  u_sel;
        logic [5:0]  banks;
        logic [15:0] addr;
        logic [7:0]  q;
        int          dly;
        logic        e_sel;
        int          e_reqs;
        logic [22:0] e_addr;
        int          e_waits;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] q,
                           input int dly, output int reqs,
                           output logic [22:0] a_seen, output int waits,
                           output logic [7:0] dout);
        bit fin;
        fin    = 0;
        reqs   = 0;
        waits  = 0;
        a_seen = '0;
        cpu_addr = a;
        mem_q    = q;
        cpu_rd   = 1'b1;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (c > 0 && !cpu_wait && !mem_req) begin
                fin = 1;
                break;
            end
            if (cpu_wait) waits++;
            if (mem_req) begin
                reqs++;
                if (reqs == 1) a_seen = mem_addr;
                mem_ack = (dly != 0) && (reqs == dly);
            end
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
        end
        if (!fin) begin
            failures++;
            checks++;
            $display("FAIL read_bound addr=%0h did not complete", a);
        end
        dout   = cpu_dout;
        cpu_rd = 1'b0;
        tick();
        tick();
    endtask

    function automatic vec_t mk(logic le, logic [1:0] lp, logic [2:0] lb,
                                logic ue, logic [7:0] us, logic [5:0] bk,
                                logic [15:0] ad, logic [7:0] q, int dly,
                                logic es, int er, logic [22:0] ea,
                                int ew, logic [7:0] ed);
        vec_t v;
        v.l_en = le; v.l_page = lp; v.l_bank = lb;
        v.u_en = ue; v.u_sel = us; v.banks = bk;
        v.addr = ad; v.q = q; v.dly = dly;
        v.e_sel = es; v.e_reqs = er; v.e_addr = ea;
        v.e_waits = ew; v.e_dout = ed;
        return v;
    endfunction

    int          reqs;
    int          waits;
    logic [22:0] a_seen;
    logic [7:0]  dout;

    initial begin
        vt[0]  = mk(1, 0, 2, 0, 8'h00, 6'd4,  16'h0123, 8'h5A, 3,
                    1, 3, 23'h408123, 4, 8'h5A);
        vt[1]  = mk(1, 0, 2, 0, 8'h00, 6'd4,  16'h0123, 8'h99, 1,
                    1, 0, 23'h0, 0, 8'h5A);
        vt[2]  = mk(1, 0, 3, 0, 8'h00, 6'd4,  16'h0123, 8'h3C, 1,
                    1, 1, 23'h40C123, 2, 8'h3C);
        vt[3]  = mk(1, 0, 3, 1, 8'h85, 6'd8,  16'hC010, 8'h11, 2,
                    1, 2, 23'h414010, 3, 8'h11);
        vt[4]  = mk(1, 0, 3, 1, 8'h07, 6'd8,  16'hC010, 8'h22, 1,
                    1, 1, 23'h40C010, 2, 8'h22);
        vt[5]  = mk(1, 0, 3, 1, 8'h00, 6'd8,  16'hC010, 8'h33, 1,
                    1, 1, 23'h404010, 2, 8'h33);
        vt[6]  = mk(1, 0, 3, 1, 8'h85, 6'd4,  16'hC010, 8'h77, 1,
                    1, 0, 23'h0, 0, 8'hFF);
        vt[7]  = mk(1, 1, 0, 0, 8'h00, 6'd4,  16'h4567, 8'h44, 1,
                    1, 1, 23'h400567, 2, 8'h44);
        vt[8]  = mk(1, 1, 0, 0, 8'h00, 6'd4,  16'h0123, 8'h88, 1,
                    0, 0, 23'h0, 0, 8'h44);
        vt[9]  = mk(1, 0, 0, 0, 8'h00, 6'd0,  16'h0010, 8'h88, 1,
                    1, 0, 23'h0, 0, 8'hFF);
        vt[10] = mk(0, 0, 0, 1, 8'h9F, 6'd32, 16'hFFFF, 8'h55, 1,
                    1, 1, 23'h47FFFF, 2, 8'h55);

        #12;
        chk("rst_dout", cpu_dout, 8'hFF);
        chk("rst_wait", cpu_wait, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 23'h0);
        chk("rst_tmo", timeout_err, 1'b0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            lower_en   = vt[i].l_en;
            lower_page = vt[i].l_page;
            lower_bank = vt[i].l_bank;
            upper_en   = vt[i].u_en;
            upper_sel  = vt[i].u_sel;
            cart_banks = vt[i].banks;
            cpu_addr   = vt[i].addr;
            #1;
            chk($sformatf("v%0d_sel", i), cart_sel, vt[i].e_sel);
            do_read(vt[i].addr, vt[i].q, vt[i].dly, reqs, a_seen,
                    waits, dout);
            chk($sformatf("v%0d_reqs", i), reqs, vt[i].e_reqs);
            chk($sformatf("v%0d_waits", i), waits, vt[i].e_waits);
            chk($sformatf("v%0d_dout", i), dout, vt[i].e_dout);
            if (vt[i].e_reqs > 0)
                chk($sformatf("v%0d_addr", i), a_seen, vt[i].e_addr);
        end

        lower_en = 1; lower_page = 0; lower_bank = 1;
        upper_en = 0; cart_banks = 6'd4;
        do_read(16'h0200, 8'h12, 0, reqs, a_seen, waits, dout);
        chk("tmo_reqs", reqs, 255);
        chk("tmo_dout", dout, 8'hFF);
        chk("tmo_err", timeout_err, 1'b1);
        do_read(16'h0201, 8'h66, 1, reqs, a_seen, waits, dout);
        chk("post_tmo_addr", a_seen, 23'h404201);
        chk("post_tmo_dout", dout, 8'h66);
        chk("tmo_sticky", timeout_err, 1'b1);

        lower_bank = 2;
        cpu_addr = 16'h0300;
        cpu_rd = 1'b1;
        tick();
        chk("ld_req", mem_req, 1'b1);
        cart_loading = 1'b1;
        tick();
        mem_q = 8'h77;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ld_dout", cpu_dout, 8'h77);
        chk("ld_req_drop", mem_req, 1'b0);
        cpu_rd = 1'b0;
        tick();
        tick();
        cpu_rd = 1'b1;
        #1;
        chk("ld_idle_wait", cpu_wait, 1'b0);
        tick();
        chk("ld_no_start", mem_req, 1'b0);
        cpu_rd = 1'b0;
        cart_loading = 1'b0;
        tick();
        do_read(16'h0300, 8'h78, 1, reqs, a_seen, waits, dout);
        chk("ld_refetch", reqs, 1);
        chk("ld_refetch_dout", dout, 8'h78);

        cpu_addr = 16'h0400;
        cpu_rd = 1'b1;
        tick();
        chk("rm_req", mem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_req_drop", mem_req, 1'b0);
        chk("rm_wait", cpu_wait, 1'b0);
        chk("rm_dout", cpu_dout, 8'hFF);
        cpu_rd = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        mem_q = 8'hAB;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rm_late_dout", cpu_dout, 8'hFF);
        chk("rm_late_req", mem_req, 1'b0);
        chk("rm_late_wait", cpu_wait, 1'b0);
        chk("rm_tmo_clr", timeout_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
